// File: rtl/ymn_lib_pkg.sv
// rtl/ymn_lib_pkg.sv - shared constants and helper functions for the ymn shift-register blocks
//
// Purpose : default geometry for the two-phase shift-register array and a
//           constant-evaluable clog2 used to size tap selects and slot counters.
// Ports   : none (package).
package ymn_lib_pkg;

  localparam int SR_LENGTH_DEF  = 18;
  localparam int DATA_WIDTH_DEF = 10;

  // Smallest r with 2**r >= n.  Callers only pass n >= 2, so the result is
  // always at least 1 and can be used directly as a vector width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ymn_sr_stage.sv
// rtl/ymn_sr_stage.sv - one master/slave stage of the two-phase shift register
//
// Purpose : holds one master word and one slave word.  The master captures d
//           on c1 edges, the slave captures the master on c2 edges.
// Ports   : MCLK    - rising-edge system clock
//           IC      - asynchronous active-low clear of both words
//           c1      - master-phase enable
//           c2      - slave-phase enable
//           d       - master input (previous slave, or the array input)
//           s       - slave word, the only externally visible state
module ymn_sr_stage
  import ymn_lib_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  MCLK,
  input  logic                  IC,
  input  logic                  c1,
  input  logic                  c2,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] s
);

  logic [DATA_WIDTH-1:0] m;

  // Both words sit in the same clocked block: when c1 and c2 are high in
  // the same cycle each side takes the other's pre-edge value, so data can
  // never fall through a stage in a single edge.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      m <= '0;
      s <= '0;
    end else begin
      if (c1) begin
        m <= d;
      end
      if (c2) begin
        s <= m;
      end
    end
  end

endmodule

// File: rtl/ymn_sr_array_tap.sv
// rtl/ymn_sr_array_tap.sv - two-phase shift-register array with tap mux and slot counter
//
// Purpose : SR_LENGTH master/slave stages of DATA_WIDTH bits, advanced one
//           stage per c1-then-c2 pair.  A slot counter tracks which slot is
//           on val, and a tap mux exposes any slave stage.
// Ports   : MCLK    - rising-edge system clock
//           IC      - asynchronous active-low reset
//           c1      - master-phase enable
//           c2      - slave-phase enable
//           inp     - data into stage 0
//           clr     - shift zero into stage 0 on this c1 instead of inp
//           resync  - force slot to 0 on the next c2
//           tap_sel - slave stage index routed to tap_val
//           val     - last slave stage (shift-register output)
//           nval    - bitwise inverse of val
//           tap_val - slave stage tap_sel, or 0 when tap_sel is out of range
//           slot    - slot index currently presented on val
//           sync    - high while slot is the last slot
module ymn_sr_array_tap
  import ymn_lib_pkg::*;
#(
  parameter  int SR_LENGTH  = SR_LENGTH_DEF,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int TAP_W      = clog2(SR_LENGTH)
) (
  input  logic                  MCLK,
  input  logic                  IC,
  input  logic                  c1,
  input  logic                  c2,
  input  logic [DATA_WIDTH-1:0] inp,
  input  logic                  clr,
  input  logic                  resync,
  input  logic [TAP_W-1:0]      tap_sel,
  output logic [DATA_WIDTH-1:0] val,
  output logic [DATA_WIDTH-1:0] nval,
  output logic [DATA_WIDTH-1:0] tap_val,
  output logic [TAP_W-1:0]      slot,
  output logic                  sync
);

  localparam logic [TAP_W-1:0] LAST_SLOT = TAP_W'(SR_LENGTH - 1);

  logic [DATA_WIDTH-1:0] d_arr [SR_LENGTH];
  logic [DATA_WIDTH-1:0] s_arr [SR_LENGTH];
  logic [TAP_W-1:0]      slot_nxt;

  // Stage 0 is fed from inp (or zero on clr); every later stage is fed from
  // the slave of the stage before it.
  assign d_arr[0] = clr ? '0 : inp;

  genvar k;
  generate
    for (k = 1; k < SR_LENGTH; k++) begin : g_link
      assign d_arr[k] = s_arr[k-1];
    end

    for (k = 0; k < SR_LENGTH; k++) begin : g_stage
      ymn_sr_stage #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_stage (
        .MCLK (MCLK),
        .IC   (IC),
        .c1   (c1),
        .c2   (c2),
        .d    (d_arr[k]),
        .s    (s_arr[k])
      );
    end
  endgenerate

  assign val  = s_arr[SR_LENGTH-1];
  assign nval = ~s_arr[SR_LENGTH-1];

  // Tap mux.  Selects at or beyond SR_LENGTH match no stage and read zero.
  always_comb begin
    tap_val = '0;
    for (int i = 0; i < SR_LENGTH; i++) begin
      if (tap_sel == TAP_W'(i)) begin
        tap_val = s_arr[i];
      end
    end
  end

  // Slot counter moves with the slave phase; resync wins over the wrap/increment.
  always_comb begin
    slot_nxt = slot;
    if (c2) begin
      if (resync || (slot == LAST_SLOT)) begin
        slot_nxt = '0;
      end else begin
        slot_nxt = slot + TAP_W'(1);
      end
    end
  end

  // sync is registered from the next slot value so it is a pure flop output
  // that changes on the same edge as slot.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      slot <= '0;
      sync <= 1'b0;
    end else begin
      slot <= slot_nxt;
      sync <= (slot_nxt == LAST_SLOT);
    end
  end

endmodule
